// File: rtl/datamemory_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the data-memory arbiter and the data memory.
// The master side drives requests and memory read data; the slave side is the arbiter.
interface datamemory_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_douta;
  logic [15:0] cpu_doutb;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [15:0] dma_dout;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_wea;
  logic [15:0] mem_douta;
  logic [15:0] mem_doutb;
  logic        addr_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  dma_req, dma_we, dma_addr, dma_din,
    input  mem_douta, mem_doutb,
    output cpu_gnt, cpu_rvalid, cpu_douta, cpu_doutb,
    output dma_gnt, dma_rvalid, dma_dout,
    output mem_addr, mem_din, mem_wea, addr_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output dma_req, dma_we, dma_addr, dma_din,
    output mem_douta, mem_doutb,
    input  cpu_gnt, cpu_rvalid, cpu_douta, cpu_doutb,
    input  dma_gnt, dma_rvalid, dma_dout,
    input  mem_addr, mem_din, mem_wea, addr_err
  );
endinterface

// File: rtl/datamemory_arbiter.sv
// Data-memory arbiter: CPU priority with an anti-starvation wait counter for DMA,
// illegal-address blocking and one-cycle read-response routing to the owning requester.
//
// state     | meaning
// OWN_NONE  | no read response due this cycle
// OWN_CPU   | last cycle granted a CPU read; respond on cpu_* now
// OWN_DMA   | last cycle granted a DMA read; respond on dma_* now
module datamemory_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  datamemory_arbiter_if.slave         bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  owner_t      owner_q;
  logic        legal_q;
  logic        err_q;
  logic [3:0]  wait_cnt;
  logic [15:0] cpu_douta_q;
  logic [15:0] cpu_doutb_q;
  logic [15:0] dma_dout_q;

  logic        cpu_gnt;
  logic        dma_gnt;
  logic        sel_we;
  logic        legal;
  logic [15:0] sel_addr;
  logic [15:0] sel_din;
  logic        cpu_rvalid;
  logic        dma_rvalid;
  logic [15:0] rd_a;
  logic [15:0] rd_b;

  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    if (!reset) begin
      if (bus.dma_req && (wait_cnt == WAIT_LIMIT)) dma_gnt = 1'b1;
      else if (bus.cpu_req)                        cpu_gnt = 1'b1;
      else if (bus.dma_req)                        dma_gnt = 1'b1;
    end
    sel_addr = 16'h0000;
    sel_din  = 16'h0000;
    sel_we   = 1'b0;
    if (cpu_gnt) begin
      sel_addr = bus.cpu_addr;
      sel_din  = bus.cpu_din;
      sel_we   = bus.cpu_we;
    end else if (dma_gnt) begin
      sel_addr = bus.dma_addr;
      sel_din  = bus.dma_din;
      sel_we   = bus.dma_we;
    end
    legal = (sel_addr[15:14] == 2'b00);
  end

  // Reset also masks a response registered just before it was asserted.
  assign cpu_rvalid = (owner_q == OWN_CPU) && !reset;
  assign dma_rvalid = (owner_q == OWN_DMA) && !reset;
  assign rd_a       = legal_q ? bus.mem_douta : 16'h0000;
  assign rd_b       = legal_q ? bus.mem_doutb : 16'h0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      legal_q     <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt    <= 4'd0;
      cpu_douta_q <= 16'h0000;
      cpu_doutb_q <= 16'h0000;
      dma_dout_q  <= 16'h0000;
    end else begin
      if (cpu_gnt && !bus.cpu_we)      owner_q <= OWN_CPU;
      else if (dma_gnt && !bus.dma_we) owner_q <= OWN_DMA;
      else                             owner_q <= OWN_NONE;
      legal_q <= legal;
      err_q   <= (cpu_gnt || dma_gnt) && !legal;
      if (bus.dma_req && !dma_gnt)
        wait_cnt <= (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 4'd1;
      else
        wait_cnt <= 4'd0;
      if (cpu_rvalid) begin
        cpu_douta_q <= rd_a;
        cpu_doutb_q <= rd_b;
      end
      if (dma_rvalid) dma_dout_q <= rd_a;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.mem_addr   = sel_addr;
  assign bus.mem_din    = sel_din;
  assign bus.mem_wea    = sel_we && legal;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.cpu_douta  = cpu_rvalid ? rd_a : cpu_douta_q;
  assign bus.cpu_doutb  = cpu_rvalid ? rd_b : cpu_doutb_q;
  assign bus.dma_dout   = dma_rvalid ? rd_a : dma_dout_q;
  assign bus.addr_err   = err_q && !reset;

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Bench for datamemory_arbiter: write-first memory model, transaction-level reference
// model, a vector table for arbitration/mux cases, hand sequences and random traffic.
module tb_datamemory_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic reset;
  datamemory_arbiter_if bus ();

  datamemory_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: 16K words, write-first port A, port B reads addr-1
  logic [15:0] mem_arr [0:16383];
  always @(posedge clk) begin
    if (bus.mem_wea) mem_arr[bus.mem_addr[13:0]] <= bus.mem_din;
    bus.mem_douta <= bus.mem_wea ? bus.mem_din : mem_arr[bus.mem_addr[13:0]];
    bus.mem_doutb <= mem_arr[14'(bus.mem_addr[13:0] - 14'd1)];
  end

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] ref_mem [0:16383];
  int          denied;
  int          pend_owner;   // 0 none, 1 cpu, 2 dma
  logic        pend_err;
  logic [15:0] pend_a, pend_b;
  logic        cpu_hold_known, dma_hold_known;
  logic [15:0] hold_ca, hold_cb, hold_d;

  logic obs_cpu_gnt, obs_dma_gnt, obs_wea, obs_cpu_rvalid;
  logic [15:0] obs_maddr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst,
                      input logic creq, input logic cwe, input logic [15:0] caddr, input logic [15:0] cdin,
                      input logic dreq, input logic dwe, input logic [15:0] daddr, input logic [15:0] ddin);
    logic eg_c, eg_d, g_we, g_legal, exp_cv, exp_dv, exp_err;
    logic [15:0] g_addr, g_din;
    reset = rst;
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_din = cdin;
    bus.dma_req = dreq; bus.dma_we = dwe; bus.dma_addr = daddr; bus.dma_din = ddin;
    #4;
    eg_c = 1'b0; eg_d = 1'b0;
    if (!rst) begin
      if (dreq && (denied >= MAX_WAIT || !creq)) eg_d = 1'b1;
      else if (creq) eg_c = 1'b1;
    end
    g_addr = eg_c ? caddr : (eg_d ? daddr : 16'h0000);
    g_din  = eg_c ? cdin  : (eg_d ? ddin  : 16'h0000);
    g_we   = eg_c ? cwe   : (eg_d ? dwe   : 1'b0);
    g_legal = (g_addr < 16'h4000);
    obs_cpu_gnt = bus.cpu_gnt; obs_dma_gnt = bus.dma_gnt; obs_wea = bus.mem_wea;
    obs_maddr = bus.mem_addr; obs_cpu_rvalid = bus.cpu_rvalid;
    chk("cpu_gnt", 16'(bus.cpu_gnt), 16'(eg_c));
    chk("dma_gnt", 16'(bus.dma_gnt), 16'(eg_d));
    chk("mem_addr", bus.mem_addr, g_addr);
    chk("mem_din", bus.mem_din, g_din);
    chk("mem_wea", 16'(bus.mem_wea), 16'(g_we && g_legal));
    exp_cv  = !rst && (pend_owner == 1);
    exp_dv  = !rst && (pend_owner == 2);
    exp_err = !rst && pend_err;
    chk("cpu_rvalid", 16'(bus.cpu_rvalid), 16'(exp_cv));
    chk("dma_rvalid", 16'(bus.dma_rvalid), 16'(exp_dv));
    chk("addr_err", 16'(bus.addr_err), 16'(exp_err));
    if (exp_cv) begin
      hold_ca = pend_a; hold_cb = pend_b; cpu_hold_known = 1'b1;
    end
    if (exp_dv) begin
      hold_d = pend_a; dma_hold_known = 1'b1;
    end
    if (cpu_hold_known) begin
      chk("cpu_douta", bus.cpu_douta, hold_ca);
      chk("cpu_doutb", bus.cpu_doutb, hold_cb);
    end
    if (dma_hold_known) chk("dma_dout", bus.dma_dout, hold_d);
    if (rst) begin
      pend_owner = 0; pend_err = 1'b0; denied = 0;
      cpu_hold_known = 1'b0; dma_hold_known = 1'b0;
    end else begin
      pend_err = (eg_c || eg_d) && !g_legal;
      pend_owner = (eg_c && !cwe) ? 1 : ((eg_d && !dwe) ? 2 : 0);
      pend_a = g_legal ? ref_mem[g_addr[13:0]] : 16'h0000;
      pend_b = g_legal ? ref_mem[14'(g_addr[13:0] - 14'd1)] : 16'h0000;
      if (g_we && g_legal) ref_mem[g_addr[13:0]] = g_din;
      if (dreq && !eg_d) denied++;
      else denied = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  typedef struct {
    logic creq; logic cwe; logic [15:0] caddr; logic [15:0] cdin;
    logic dreq; logic dwe; logic [15:0] daddr; logic [15:0] ddin;
    logic e_cg; logic e_dg; logic e_wea; logic [15:0] e_maddr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem_arr[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    bus.mem_douta = 16'h0000; bus.mem_doutb = 16'h0000;
    denied = 0; pend_owner = 0; pend_err = 1'b0; pend_a = 16'h0; pend_b = 16'h0;
    cpu_hold_known = 1'b0; dma_hold_known = 1'b0;
    hold_ca = 16'h0; hold_cb = 16'h0; hold_d = 16'h0;

    vecs[0] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0005};
    vecs[1] = '{1'b1, 1'b1, 16'h0007, 16'h7777, 1'b1, 1'b0, 16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0007};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h2020, 1'b0, 1'b1, 1'b1, 16'h0020};
    vecs[3] = '{1'b1, 1'b1, 16'hC001, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hC001};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h4002, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h4002};
    vecs[6] = '{1'b1, 1'b0, 16'h3FFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h3FFF};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};

    // reset held with both requesting
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("rst_cpu_gnt", 16'(obs_cpu_gnt), 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("rst_dma_gnt", 16'(obs_dma_gnt), 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 1'b0, 16'h0006, 16'h0);
    chk("post_rst_cpu_first", 16'(obs_cpu_gnt), 16'h1);
    idle();

    // write then read back
    step(1'b0, 1'b1, 1'b1, 16'h0005, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("raw_cpu_rvalid", 16'(bus.cpu_rvalid), 16'h1);
    chk("raw_cpu_douta", bus.cpu_douta, 16'h1234);
    chk("raw_dma_rvalid", 16'(bus.dma_rvalid), 16'h0);

    // second stack operand from addr-1
    step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0011, 16'hBBBB, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("pair_douta", bus.cpu_douta, 16'hBBBB);
    chk("pair_doutb", bus.cpu_doutb, 16'hAAAA);
    idle();

    // vector table
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cdin,
           vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].ddin);
      chk($sformatf("vec%0d_cpu_gnt", i), 16'(obs_cpu_gnt), 16'(vecs[i].e_cg));
      chk($sformatf("vec%0d_dma_gnt", i), 16'(obs_dma_gnt), 16'(vecs[i].e_dg));
      chk($sformatf("vec%0d_wea", i), 16'(obs_wea), 16'(vecs[i].e_wea));
      chk($sformatf("vec%0d_maddr", i), obs_maddr, vecs[i].e_maddr);
    end
    idle();

    // starvation guard: both requesting continuously
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0011, 16'h0);
      chk($sformatf("starve%0d_dma_gnt", i), 16'(obs_dma_gnt), 16'((i % 5) == 4));
      chk($sformatf("starve%0d_cpu_gnt", i), 16'(obs_cpu_gnt), 16'((i % 5) != 4));
      if ((i % 5) == 4) begin
        chk("starve_dma_rvalid", 16'(bus.dma_rvalid), 16'h1);
        chk("starve_cpu_rvalid", 16'(bus.cpu_rvalid), 16'h0);
        chk("starve_dma_dout", bus.dma_dout, 16'hBBBB);
      end
    end
    idle();

    // illegal addresses
    step(1'b0, 1'b1, 1'b1, 16'h0003, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h8003, 16'hFFFF);
    chk("ill_wr_gnt", 16'(obs_dma_gnt), 16'h1);
    chk("ill_wr_wea", 16'(obs_wea), 16'h0);
    chk("ill_wr_err", 16'(bus.addr_err), 16'h1);
    idle();
    chk("ill_err_pulse_end", 16'(bus.addr_err), 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0003, 16'h0);
    chk("ill_prior_contents", bus.dma_dout, 16'h5555);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h4000, 16'h0);
    chk("ill_rd_rvalid", 16'(bus.dma_rvalid), 16'h1);
    chk("ill_rd_dout", bus.dma_dout, 16'h0000);
    chk("ill_rd_err", 16'(bus.addr_err), 16'h1);
    idle();

    // reset during a pending read
    step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_mid_rvalid_n1", 16'(obs_cpu_rvalid), 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 1'b0, 16'h0006, 16'h0);
    chk("rst_mid_rvalid_n2", 16'(obs_cpu_rvalid), 16'h0);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 1'b0, 16'h0006, 16'h0);
      chk($sformatf("rst_cnt%0d_dma_gnt", i), 16'(obs_dma_gnt), 16'(i == 4));
    end
    idle();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ca, da;
      ca = 16'($urandom_range(0, 15));
      da = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ca[15:14] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) da[15:14] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) ca = 16'h3FFF;
      step(($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ca, 16'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), da, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamemory_arbiter.md
Name: datamemory_arbiter

Overview:
- Shares the single-ported-write data memory (14-bit word address, 16-bit data, port B reads addr-1) between two requesters: the CPU stack datapath and a DMA/debug loader.
- Sits between the requesters and the data memory block.
- Grants at most one access per cycle, routes read data back to the owning requester, and blocks illegal addresses (addr[15:14] != 0) instead of just reporting them.
- CPU has priority; a wait counter prevents DMA starvation.

Parameters:
- MAX_WAIT, 4, consecutive cycles DMA may be denied while requesting before it is forced a grant (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write enable (1 = write, 0 = read).
- cpu_addr  in  16  CPU word address.
- cpu_din  in  16  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_douta  out  16  CPU read data at addr.
- cpu_doutb  out  16  CPU read data at addr-1 (second stack operand).
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write enable.
- dma_addr  in  16  DMA word address.
- dma_din  in  16  DMA write data.
- dma_gnt  out  1  DMA access accepted this cycle (combinational).
- dma_rvalid  out  1  DMA read data valid (registered).
- dma_dout  out  16  DMA read data at addr.
- mem_addr  out  16  to data memory addr.
- mem_din  out  16  to data memory din.
- mem_wea  out  1  to data memory wea.
- mem_douta  in  16  from data memory douta; valid 1 cycle after address presented.
- mem_doutb  in  16  from data memory doutb; same timing.
- addr_err  out  1  one-cycle pulse: a granted access had addr[15:14] != 0.

Behaviour:
- Reset: cpu_rvalid = dma_rvalid = 0, addr_err = 0, wait counter = 0, response owner = NONE, mem_wea = 0. Gnt outputs are 0 while reset is high, regardless of req.
- Arbitration is combinational each cycle:
  - If dma_req and wait_cnt == MAX_WAIT, grant DMA.
  - Otherwise, if cpu_req, grant CPU.
  - Otherwise, if dma_req, grant DMA.
  - Otherwise, grant none.
  - Never both gnt high.
- Wait counter:
  - If dma_req and not dma_gnt, increment (saturating at MAX_WAIT).
  - If dma_gnt or !dma_req, clear to 0.
- Mem mux:
  - mem_addr/mem_din follow the granted requester.
  - No grant: mem_addr = 0, mem_din = 0.
  - mem_wea = granted_we AND legal, where legal = (granted_addr[15:14] == 0).
- Illegal access:
  - Still granted (requester not stalled).
  - Write suppressed (mem_wea = 0).
  - addr_err = 1 on the next cycle.
  - If it is a read: rvalid still asserted next cycle with data forced to 0.
- Read latency is exactly 1 cycle:
  - A granted read at cycle N registers owner (CPU/DMA) and the legal bit.
  - At N+1, the owner's rvalid = 1 and its dout = mem_douta (and cpu_doutb = mem_doutb), or 0 if illegal.
  - The other requester's rvalid = 0.
- Writes produce no rvalid. Write takes effect at the grant edge.
- Back-to-back: a new grant every cycle is allowed. A response and the next grant overlap (pipelined, no bubbles).
- Read-after-write to the same address on consecutive cycles returns the new data (memory write-first). The arbiter adds no forwarding.
- Data outputs hold their last value when rvalid = 0.
- Reset asserted mid-operation: any pending response is dropped (no rvalid the following cycle); the counter clears.
- cpu_doutb at addr = 0 returns the contents of word 0x3FFF (14-bit wrap in the memory); the arbiter passes it through unchanged.

Test Plan:
- Reset held 2 cycles with cpu_req = dma_req = 1 -> both gnt 0, all rvalid/addr_err 0. Release -> cpu_gnt = 1 first cycle.
- CPU write 0x1234 to 0x0005, then CPU read 0x0005 next cycle -> cpu_rvalid = 1 one cycle after the read grant, cpu_douta = 0x1234, dma_rvalid = 0.
- CPU writes 0xAAAA to 0x0010 and 0xBBBB to 0x0011, then reads 0x0011 -> cpu_douta = 0xBBBB, cpu_doutb = 0xAAAA.
- cpu_req and dma_req held high continuously, MAX_WAIT = 4:
  - cpu_gnt for 4 cycles, then dma_gnt for 1 cycle, then cpu_gnt resumes.
  - Pattern repeats every 5 cycles.
  - A DMA read response lands only on dma_rvalid/dma_dout.
- DMA write 0xFFFF to 0x8003 -> dma_gnt = 1, mem_wea = 0, addr_err pulses once. A subsequent read of 0x0003 returns the prior contents. A read of 0x4000 -> dma_rvalid = 1, dma_dout = 0x0000, addr_err = 1.
- CPU read granted at cycle N, reset asserted at N+1 -> cpu_rvalid stays 0 at N+1 and N+2; wait counter = 0.
